// File: rtl/ps2_num_input.sv
// PS/2 keyboard numeric entry: filtered line receiver, scancode decoder and a
// decimal accumulator that hands a committed value to the CPU.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a start bit (data low on a PS/2 clock fall)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking stop bit and odd parity, then acting on the code
module ps2_num_input #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_DIGITS = 5,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              kbd,
   input  logic                    status,
   output logic                    control,
   output logic [DATA_WIDTH-1:0]   in,
   output logic [4*MAX_DIGITS-1:0] digits,
   output logic                    frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int DB = 4 * MAX_DIGITS;
   localparam logic [DATA_WIDTH+3:0] MAXV = {4'b0, {DATA_WIDTH{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]            sync1, sync2, filt;
   logic                  clk_q, fall, timeout, code_ok, err_d;
   state_t                state_q, state_d;
   logic [7:0]            sh_q;
   logic                  par_q;
   logic [2:0]            bit_cnt_q;
   logic [TW-1:0]         tmr_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [CW-1:0]         cnt_q;
   logic                  brk_q;
   logic [4:0]            dec;
   logic [DB-1:0]         dig_push, dig_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
      end else begin
         sync1 <= kbd;
         sync2 <= sync1;
      end
   end

   // Each line flips only after FILTER_LEN consecutive samples disagree with it.
   for (genvar g = 0; g < 2; g++) begin : g_filt
      logic          f_q;
      logic [FW-1:0] fcnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            f_q    <= 1'b1;
            fcnt_q <= FW'(FILTER_LEN - 1);
         end else if (sync2[g] == f_q) begin
            fcnt_q <= FW'(FILTER_LEN - 1);
         end else if (fcnt_q == '0) begin
            f_q    <= sync2[g];
            fcnt_q <= FW'(FILTER_LEN - 1);
         end else begin
            fcnt_q <= fcnt_q - 1'b1;
         end
      end
      assign filt[g] = f_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clk_q <= 1'b1;
      else        clk_q <= filt[0];
   end

   assign fall    = clk_q & ~filt[0];
   assign timeout = (state_q != S_IDLE) && !fall && (tmr_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (fall && !filt[1])               state_d = S_DATA;
         S_DATA:   if (fall && bit_cnt_q == 3'd7)      state_d = S_PARITY;
         S_PARITY: if (fall)                           state_d = S_STOP;
         S_STOP:   if (fall)                           state_d = S_IDLE;
         default:                                      state_d = S_IDLE;
      endcase
      if (timeout) state_d = S_IDLE;
   end

   always_comb begin
      code_ok = 1'b0;
      err_d   = timeout;
      if (state_q == S_STOP && fall) begin
         if (filt[1] && (^{sh_q, par_q})) code_ok = 1'b1;
         else                             err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q      <= '0;
         par_q     <= 1'b0;
         bit_cnt_q <= '0;
         tmr_q     <= TW'(TIMEOUT - 1);
         frame_err <= 1'b0;
      end else begin
         frame_err <= err_d;
         if (state_q == S_IDLE || fall) tmr_q <= TW'(TIMEOUT - 1);
         else if (tmr_q != '0)          tmr_q <= tmr_q - 1'b1;
         if (fall) begin
            case (state_q)
               S_IDLE:   bit_cnt_q <= '0;
               S_DATA: begin
                  sh_q      <= {filt[1], sh_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
               S_PARITY: par_q <= filt[1];
               default: ;
            endcase
         end
      end
   end

   function automatic logic [4:0] decode(input logic [7:0] c);
      case (c)
         8'h45: return 5'h10;
         8'h16: return 5'h11;
         8'h1E: return 5'h12;
         8'h26: return 5'h13;
         8'h25: return 5'h14;
         8'h2E: return 5'h15;
         8'h36: return 5'h16;
         8'h3D: return 5'h17;
         8'h3E: return 5'h18;
         8'h46: return 5'h19;
         default: return 5'h00;
      endcase
   endfunction

   // Saturating at every step equals saturating acc*10+d incrementally.
   function automatic logic [DATA_WIDTH-1:0] bcd_val(input logic [DB-1:0] bcd);
      logic [DATA_WIDTH+3:0] v;
      v = '0;
      for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
         v = v * (DATA_WIDTH + 4)'(10) + (DATA_WIDTH + 4)'(bcd[4*i +: 4]);
         if (v > MAXV) v = MAXV;
      end
      return v[DATA_WIDTH-1:0];
   endfunction

   assign dec      = decode(sh_q);
   assign dig_push = (digits << 4) | DB'(dec[3:0]);
   assign dig_pop  = digits >> 4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         control <= 1'b0;
         in      <= '0;
         digits  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         brk_q   <= 1'b0;
      end else begin
         if (control && !status) control <= 1'b0;
         if (code_ok) begin
            if (sh_q == 8'hF0) begin
               brk_q <= 1'b1;
            end else if (sh_q == 8'hE0) begin
               brk_q <= brk_q;
            end else if (brk_q) begin
               brk_q <= 1'b0;
            end else if (dec[4]) begin
               if (cnt_q < CW'(MAX_DIGITS)) begin
                  digits <= dig_push;
                  acc_q  <= bcd_val(dig_push);
                  cnt_q  <= cnt_q + 1'b1;
               end
            end else if (sh_q == 8'h66) begin
               if (cnt_q != '0) begin
                  digits <= dig_pop;
                  acc_q  <= bcd_val(dig_pop);
                  cnt_q  <= cnt_q - 1'b1;
               end
            end else if (sh_q == 8'h5A) begin
               if (status && cnt_q != '0 && !control) begin
                  in      <= acc_q;
                  control <= 1'b1;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  digits  <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_num_input.sv
// Directed bench for ps2_num_input: bit-banged PS/2 frames, a commit/error
// scoreboard, and immediate checks of the BCD echo and CPU handshake.
module tb_ps2_num_input;
   localparam int DW = 16, MD = 5, FL = 8, TO = 1000, H = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    kbd = 2'b11;
   logic          status = 1'b0;
   logic          control;
   logic [DW-1:0] in_v;
   logic [4*MD-1:0] digits;
   logic          frame_err;

   int n_cmp = 0, n_bad = 0;
   int exp_in_q[$];
   int exp_err_q[$];
   logic ctrl_q = 1'b0;

   always #5 clk = ~clk;

   ps2_num_input #(.DATA_WIDTH(DW), .MAX_DIGITS(MD), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .kbd(kbd), .status(status),
      .control(control), .in(in_v), .digits(digits), .frame_err(frame_err));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: commits and frame errors must match what the stimulus queued.
   always @(negedge clk) begin
      if (control === 1'b1 && ctrl_q !== 1'b1) begin
         check("commit_pending", 32'(exp_in_q.size() > 0), 32'd1);
         if (exp_in_q.size() > 0) check("commit_value", 32'(in_v), 32'(exp_in_q.pop_front()));
      end
      if (frame_err === 1'b1) begin
         check("err_pending", 32'(exp_err_q.size() > 0), 32'd1);
         if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
      end
      ctrl_q = control;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] b, input logic flip_par, input logic stop);
      return {stop, (~^b) ^ flip_par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] fr, input int n);
      for (int i = 0; i < n; i++) begin
         kbd[1] = fr[i];
         cyc(H);
         kbd[0] = 1'b0;
         cyc(H);
         kbd[0] = 1'b1;
      end
      kbd[1] = 1'b1;
      cyc(3 * H);
   endtask

   task automatic key(input logic [7:0] b);
      send_bits(mkframe(b, 1'b0, 1'b1), 11);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int k = 0;
      while ((exp_err_q.size() + exp_in_q.size()) != 0 && k < budget) begin
         cyc(1);
         k++;
      end
      check(tag, 32'(exp_err_q.size() + exp_in_q.size()), 32'd0);
   endtask

   initial begin
      cyc(3);
      check("rst_control", 32'(control), 32'd0);
      check("rst_in", 32'(in_v), 32'd0);
      check("rst_digits", 32'(digits), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      rst_n = 1'b1;
      cyc(5);

      // 1,2,3 enter
      status = 1'b1;
      key(8'h16); check("d_1", 32'(digits), 32'h1);
      key(8'h1E); check("d_12", 32'(digits), 32'h12);
      key(8'h26); check("d_123", 32'(digits), 32'h123);
      exp_in_q.push_back(123);
      key(8'h5A);
      wait_drain("commit_123_drain", 10);
      check("c123_control", 32'(control), 32'd1);
      check("c123_digits", 32'(digits), 32'h0);
      check("c123_in", 32'(in_v), 32'd123);
      cyc(5);
      check("c123_hold", 32'(control), 32'd1);
      status = 1'b0;
      cyc(1);
      check("c123_release", 32'(control), 32'd0);
      check("c123_in_kept", 32'(in_v), 32'd123);

      // saturation and digit limit
      key(8'h36); key(8'h2E); key(8'h2E); key(8'h26);
      check("d_6553", 32'(digits), 32'h6553);
      key(8'h36); check("d_65536", 32'(digits), 32'h65536);
      key(8'h16); check("d_sixth_ignored", 32'(digits), 32'h65536);
      status = 1'b1;
      exp_in_q.push_back(65535);
      key(8'h5A);
      wait_drain("commit_sat_drain", 10);
      check("sat_in", 32'(in_v), 32'd65535);
      check("sat_digits", 32'(digits), 32'h0);
      status = 1'b0;
      cyc(2);

      // backspace and enter qualifiers
      key(8'h25); key(8'h3D); check("d_47", 32'(digits), 32'h47);
      key(8'h66); check("d_bksp", 32'(digits), 32'h4);
      status = 1'b1;
      exp_in_q.push_back(4);
      key(8'h5A);
      wait_drain("commit_4_drain", 10);
      check("c4_in", 32'(in_v), 32'd4);
      key(8'h25); check("d_4_while_ctrl", 32'(digits), 32'h4);
      key(8'h5A);
      check("enter_ctrl_busy_digits", 32'(digits), 32'h4);
      check("enter_ctrl_busy_in", 32'(in_v), 32'd4);
      status = 1'b0;
      cyc(2);
      check("c4_release", 32'(control), 32'd0);
      key(8'h5A);
      check("enter_nostatus_ctrl", 32'(control), 32'd0);
      check("enter_nostatus_digits", 32'(digits), 32'h4);
      key(8'h66); check("d_bksp_empty", 32'(digits), 32'h0);
      key(8'h66); check("d_bksp_noop", 32'(digits), 32'h0);
      status = 1'b1;
      key(8'h5A);
      check("enter_empty_ctrl", 32'(control), 32'd0);
      status = 1'b0;

      // frame errors and timeout
      exp_err_q.push_back(1);
      send_bits(mkframe(8'h16, 1'b1, 1'b1), 11);
      wait_drain("err_parity_drain", 10);
      check("err_parity_digits", 32'(digits), 32'h0);
      exp_err_q.push_back(1);
      send_bits(mkframe(8'h16, 1'b0, 1'b0), 11);
      wait_drain("err_stop_drain", 10);
      check("err_stop_digits", 32'(digits), 32'h0);
      exp_err_q.push_back(1);
      send_bits(mkframe(8'h16, 1'b0, 1'b1), 4);
      check("timeout_not_early", 32'(exp_err_q.size()), 32'd1);
      wait_drain("timeout_drain", TO + 200);
      key(8'h16); check("after_timeout_d1", 32'(digits), 32'h1);

      // break and extended prefixes
      key(8'hF0); key(8'h16); check("brk_ignored", 32'(digits), 32'h1);
      key(8'hE0); key(8'hF0); key(8'h16); check("e0_brk_ignored", 32'(digits), 32'h1);
      key(8'hF0); key(8'hE0); key(8'h16); check("brk_kept_over_e0", 32'(digits), 32'h1);
      key(8'h16); check("make_after_brk", 32'(digits), 32'h11);

      // short glitches on the PS/2 clock with data held low
      kbd[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         kbd[0] = 1'b0; cyc(FL - 3);
         kbd[0] = 1'b1; cyc(FL);
      end
      kbd[1] = 1'b1;
      cyc(H);
      key(8'h1E); check("glitch_d112", 32'(digits), 32'h112);

      // reset mid-entry and mid-frame
      status = 1'b1;
      exp_in_q.push_back(112);
      key(8'h5A);
      wait_drain("commit_112_drain", 10);
      status = 1'b0;
      key(8'h26);
      send_bits(mkframe(8'h26, 1'b0, 1'b1), 5);
      rst_n = 1'b0;
      cyc(2);
      check("midrst_control", 32'(control), 32'd0);
      check("midrst_in", 32'(in_v), 32'd0);
      check("midrst_digits", 32'(digits), 32'h0);
      check("midrst_frame_err", 32'(frame_err), 32'd0);
      kbd = 2'b11;
      rst_n = 1'b1;
      cyc(5);
      key(8'h1E); check("post_rst_d2", 32'(digits), 32'h2);
      cyc(TO + 100);
      check("final_queues", 32'(exp_err_q.size() + exp_in_q.size()), 32'd0);
      check("final_control", 32'(control), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
